// File: rtl/or_1bit_unit.sv
// Lane-wise OR gate with a registered result copy, a registered any-bit flag
// and a saturating count of cycles with a nonzero result.
module or_1bit_unit #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             any_q,
  output logic [CNT_W-1:0] act_cnt,
  output logic             act_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res_d, res_q;
  logic             any_d, any_r_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Combinational OR; independent of clk and rst.
  assign c = a | b;

  // Next-state: capture the OR result and advance the counter until it saturates.
  always_comb begin
    res_d = a | b;
    any_d = |(a | b);
    cnt_d = cnt_q;
    if (any_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      any_r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      res_q   <= res_d;
      any_r_q <= any_d;
      cnt_q   <= cnt_d;
    end
  end

  assign c_q     = res_q;
  assign any_q   = any_r_q;
  assign act_cnt = cnt_q;
  assign act_sat = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_or_1bit_unit.sv
// Bench for or_1bit_unit: default 1-bit instance, a 2-bit-counter instance and
// a pair of 4-lane instances fed identical random stimulus.
module tb_or_1bit_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a1, b1, c1, cq1, any1, sat1;
  logic [15:0] cnt1;

  logic        as, bs, cs, cqs, anys, sats;
  logic [1:0]  cnts;

  logic [3:0]  a4, b4, c4, cq4, c4k, cq4k;
  logic        any4, sat4, any4k, sat4k;
  logic [7:0]  cnt4, cnt4k;

  int checks = 0;
  int errors = 0;

  int exp_cnt1, exp_cnts, exp_cnt4;

  or_1bit_unit #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .c_q(cq1),
    .any_q(any1), .act_cnt(cnt1), .act_sat(sat1));

  or_1bit_unit #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(as), .b(bs), .c(cs), .c_q(cqs),
    .any_q(anys), .act_cnt(cnts), .act_sat(sats));

  or_1bit_unit #(.WIDTH(4), .CNT_W(8)) dut_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .c_q(cq4),
    .any_q(any4), .act_cnt(cnt4), .act_sat(sat4));

  or_1bit_unit #(.WIDTH(4), .CNT_W(8)) dut_w4_copy (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4k), .c_q(cq4k),
    .any_q(any4k), .act_cnt(cnt4k), .act_sat(sat4k));

  task automatic test_reset();
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; as = 1'b0; bs = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_cnt1 = 0; exp_cnts = 0; exp_cnt4 = 0;
    checks++; if (cq1 !== 1'b0) begin errors++; $display("FAIL reset_cq1 got %b exp 0", cq1); end
    checks++; if (any1 !== 1'b0) begin errors++; $display("FAIL reset_any1 got %b exp 0", any1); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL reset_sat1 got %b exp 0", sat1); end
    checks++; if (cnts !== 2'd0) begin errors++; $display("FAIL reset_cnts got %0d exp 0", cnts); end
    checks++; if (sats !== 1'b0) begin errors++; $display("FAIL reset_sats got %b exp 0", sats); end
    checks++; if (cnt4 !== 8'd0) begin errors++; $display("FAIL reset_cnt4 got %0d exp 0", cnt4); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (c1 !== 1'b0) begin errors++; $display("FAIL idle_c1 got %b exp 0", c1); end
    @(posedge clk); #1;
    checks++; if (cq1 !== 1'b0) begin errors++; $display("FAIL idle_cq1 got %b exp 0", cq1); end
    checks++; if (any1 !== 1'b0) begin errors++; $display("FAIL idle_any1 got %b exp 0", any1); end
    checks++; if (cnt1 !== 16'(exp_cnt1)) begin errors++; $display("FAIL idle_cnt1 got %0d exp %0d", cnt1, exp_cnt1); end
  endtask

  task automatic test_truth_table();
    logic exp_c;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = (i >= 2);
      b1 = (i % 2 == 1);
      exp_c = (i != 0);
      #1;
      checks++; if (c1 !== exp_c) begin errors++; $display("FAIL tt_c a=%b b=%b got %b exp %b", a1, b1, c1, exp_c); end
      @(posedge clk); #1;
      if (exp_c) exp_cnt1++;
      checks++; if (cq1 !== exp_c) begin errors++; $display("FAIL tt_cq a=%b b=%b got %b exp %b", a1, b1, cq1, exp_c); end
      checks++; if (any1 !== exp_c) begin errors++; $display("FAIL tt_any a=%b b=%b got %b exp %b", a1, b1, any1, exp_c); end
    end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL tt_cnt got %0d exp 3", cnt1); end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL rstpri_c got %b exp 1", c1); end
      @(posedge clk); #1;
      checks++; if (cq1 !== 1'b0) begin errors++; $display("FAIL rstpri_cq got %b exp 0", cq1); end
      checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rstpri_cnt got %0d exp 0", cnt1); end
      checks++; if (any1 !== 1'b0) begin errors++; $display("FAIL rstpri_any got %b exp 0", any1); end
      @(negedge clk);
    end
    exp_cnt1 = 0; exp_cnts = 0; exp_cnt4 = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_cnt1++;
    checks++; if (cq1 !== 1'b1) begin errors++; $display("FAIL rstrel_cq got %b exp 1", cq1); end
    checks++; if (cnt1 !== 16'(exp_cnt1)) begin errors++; $display("FAIL rstrel_cnt got %0d exp %0d", cnt1, exp_cnt1); end
    @(negedge clk);
    a1 = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    as = 1'b1; bs = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (exp_cnts < 3) exp_cnts++;
      checks++; if (cnts !== 2'(exp_cnts)) begin errors++; $display("FAIL sat_cnt edge%0d got %0d exp %0d", k, cnts, exp_cnts); end
      checks++; if (sats !== (exp_cnts == 3)) begin errors++; $display("FAIL sat_flag edge%0d got %b exp %b", k, sats, exp_cnts == 3); end
      checks++; if (cqs !== 1'b1) begin errors++; $display("FAIL sat_cq edge%0d got %b exp 1", k, cqs); end
    end
    @(negedge clk);
    as = 1'b0;
  endtask

  task automatic test_width4();
    @(negedge clk);
    a4 = 4'b0101; b4 = 4'b0011;
    #1;
    checks++; if (c4 !== 4'b0111) begin errors++; $display("FAIL w4_c got %b exp 0111", c4); end
    @(posedge clk); #1;
    exp_cnt4++;
    checks++; if (cq4 !== 4'b0111) begin errors++; $display("FAIL w4_cq got %b exp 0111", cq4); end
    checks++; if (any4 !== 1'b1) begin errors++; $display("FAIL w4_any got %b exp 1", any4); end
    checks++; if (cnt4 !== 8'(exp_cnt4)) begin errors++; $display("FAIL w4_cnt got %0d exp %0d", cnt4, exp_cnt4); end
    @(negedge clk);
    a4 = '0; b4 = '0;
    @(posedge clk); #1;
    checks++; if (any4 !== 1'b0) begin errors++; $display("FAIL w4_any_idle got %b exp 0", any4); end
    checks++; if (cnt4 !== 8'(exp_cnt4)) begin errors++; $display("FAIL w4_cnt_hold got %0d exp %0d", cnt4, exp_cnt4); end
  endtask

  task automatic test_random();
    logic [3:0] exp_c4;
    logic       exp_c1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      for (int i = 0; i < 4; i++) exp_c4[i] = (a4[i] == 1'b1) || (b4[i] == 1'b1);
      exp_c1 = (a1 == 1'b1) || (b1 == 1'b1);
      #1;
      checks++; if (c4 !== exp_c4) begin errors++; $display("FAIL rnd_c4 n=%0d got %b exp %b", n, c4, exp_c4); end
      checks++; if (c4 !== c4k) begin errors++; $display("FAIL rnd_c4_copy n=%0d got %b copy %b", n, c4, c4k); end
      checks++; if (c1 !== exp_c1) begin errors++; $display("FAIL rnd_c1 n=%0d got %b exp %b", n, c1, exp_c1); end
      @(posedge clk); #1;
      if (exp_c4 != 0 && exp_cnt4 < 255) exp_cnt4++;
      if (exp_c1) exp_cnt1++;
      checks++; if (cq4 !== exp_c4) begin errors++; $display("FAIL rnd_cq4 n=%0d got %b exp %b", n, cq4, exp_c4); end
      checks++; if (any4 !== (exp_c4 != 0)) begin errors++; $display("FAIL rnd_any4 n=%0d got %b exp %b", n, any4, exp_c4 != 0); end
      checks++; if (cnt4 !== 8'(exp_cnt4)) begin errors++; $display("FAIL rnd_cnt4 n=%0d got %0d exp %0d", n, cnt4, exp_cnt4); end
      checks++; if (sat4 !== (exp_cnt4 == 255)) begin errors++; $display("FAIL rnd_sat4 n=%0d got %b exp %b", n, sat4, exp_cnt4 == 255); end
      checks++; if ({cq4k, any4k, cnt4k, sat4k} !== {cq4, any4, cnt4, sat4}) begin
        errors++; $display("FAIL rnd_copy_regs n=%0d got %h copy %h", n, {cq4, any4, cnt4, sat4}, {cq4k, any4k, cnt4k, sat4k});
      end
      checks++; if (cnt1 !== 16'(exp_cnt1)) begin errors++; $display("FAIL rnd_cnt1 n=%0d got %0d exp %0d", n, cnt1, exp_cnt1); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a1 = 1'b1; as = 1'b1; a4 = 4'hF; b4 = 4'h0; rst = 1'b1;
    #1;
    checks++; if (c4 !== 4'hF) begin errors++; $display("FAIL midrst_c4 got %b exp 1111", c4); end
    @(posedge clk); #1;
    exp_cnt1 = 0; exp_cnts = 0; exp_cnt4 = 0;
    checks++; if (cq4 !== 4'h0) begin errors++; $display("FAIL midrst_cq4 got %b exp 0000", cq4); end
    checks++; if (cnt4 !== 8'd0) begin errors++; $display("FAIL midrst_cnt4 got %0d exp 0", cnt4); end
    checks++; if (sat4 !== 1'b0) begin errors++; $display("FAIL midrst_sat4 got %b exp 0", sat4); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL midrst_cnt1 got %0d exp 0", cnt1); end
    checks++; if (cnts !== 2'd0) begin errors++; $display("FAIL midrst_cnts got %0d exp 0", cnts); end
    @(negedge clk);
    rst = 1'b0; a1 = 1'b0; as = 1'b0; a4 = '0;
    @(posedge clk); #1;
    checks++; if (cnt4 !== 8'(exp_cnt4)) begin errors++; $display("FAIL midrst_hold_cnt4 got %0d exp %0d", cnt4, exp_cnt4); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_reset_priority();
    test_saturation();
    test_width4();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
